ov7670_config_sequencer: RTL and testbench

Parametrised sequencer that walks a synchronous configuration table of {register, value} entries and issues one SCCB write request per entry to the downstream SCCB master over a valid/ready handshake. Decodes the table's in-band markers: END terminates the walk; DELAY waits a parametrised cycle count. Adds start/restart, per-write completion tracking, NACK retry with a bounded error exit, and status outputs. Sits between the camera config table and the SCCB master, below the top-level camera/VGA pipeline.

---
 rtl/ov7670_config_sequencer_pkg.sv | 37 +++
 rtl/ov7670_config_sequencer_if.sv | 27 ++
 rtl/cfg_delay_timer.sv | 30 +++
 rtl/ov7670_config_sequencer.sv | 164 ++++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_config_sequencer_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer.
// Holds the FSM state enum, default table markers and entry field helpers.
package ov7670_cfg_pkg;

  localparam int DEF_REG_W   = 8;
  localparam int DEF_VAL_W   = 8;
  localparam int DEF_ENTRY_W = DEF_REG_W + DEF_VAL_W;

  localparam logic [DEF_ENTRY_W-1:0] DEF_END_MARK   = 16'hFFFF;
  localparam logic [DEF_ENTRY_W-1:0] DEF_DELAY_MARK = 16'hFFF0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DELAY     = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } cfg_state_t;

  // Field helpers for the default 8/8 entry layout {register, value}.
  function automatic logic [DEF_REG_W-1:0] entry_reg(input logic [DEF_ENTRY_W-1:0] e);
    return e[DEF_ENTRY_W-1:DEF_VAL_W];
  endfunction

  function automatic logic [DEF_VAL_W-1:0] entry_val(input logic [DEF_ENTRY_W-1:0] e);
    return e[DEF_VAL_W-1:0];
  endfunction

  function automatic logic [DEF_ENTRY_W-1:0] make_entry(input logic [DEF_REG_W-1:0] r,
                                                        input logic [DEF_VAL_W-1:0] v);
    return {r, v};
  endfunction

endpackage

// File: rtl/ov7670_config_sequencer_if.sv
// SCCB write-request channel between the config sequencer and the SCCB master.
// req_valid/req_ready: a request transfers on a clock edge where both are high;
// once req_valid rises, it and req_reg/req_data stay stable until that transfer.
// wr_done pulses once per transferred request; wr_nack qualifies that pulse.
interface ov7670_config_sequencer_if #(
  parameter int REG_W = 8,
  parameter int VAL_W = 8
) ();

  logic             req_valid;
  logic             req_ready;
  logic [REG_W-1:0] req_reg;
  logic [VAL_W-1:0] req_data;
  logic             wr_done;
  logic             wr_nack;

  modport master (
    output req_valid, req_reg, req_data,
    input  req_ready, wr_done, wr_nack
  );

  modport slave (
    input  req_valid, req_reg, req_data,
    output req_ready, wr_done, wr_nack
  );

endinterface

// File: rtl/cfg_delay_timer.sv
// Down-counter for DELAY table entries: load starts a CYCLES-long dwell and
// expired is high on the last cycle of that dwell while en is asserted.
module cfg_delay_timer #(
  parameter int CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = en && (count == '0);

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks an external registered config ROM and issues one SCCB write per entry,
// honouring END/DELAY markers, NACK retries and a sticky done/err status.
module ov7670_config_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int                         ADDR_W       = 8,
  parameter int                         REG_W        = 8,
  parameter int                         VAL_W        = 8,
  parameter logic [REG_W+VAL_W-1:0]     END_MARK     = DEF_END_MARK,
  parameter logic [REG_W+VAL_W-1:0]     DELAY_MARK   = DEF_DELAY_MARK,
  parameter int                         DELAY_CYCLES = 250000,
  parameter int                         MAX_RETRY    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [REG_W+VAL_W-1:0] rom_data,
  ov7670_config_sequencer_if.master sccb,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_W:0]        wr_count,
  output cfg_state_t             fsm_state
);

  localparam int ENTRY_W = REG_W + VAL_W;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [ADDR_W-1:0]  ADDR_LAST = '1;

  cfg_state_t         state, state_next;
  logic [RETRY_W-1:0] retry;

  logic is_end, is_delay, at_last, retry_left;
  logic start_walk, load_delay, latch_req, wr_ack, wr_retry, advance;
  logic delay_expired;

  assign is_end     = (rom_data == END_MARK);
  assign is_delay   = (rom_data == DELAY_MARK);
  assign at_last    = (rom_addr == ADDR_LAST);
  assign retry_left = (retry < RETRY_LIM);
  assign fsm_state  = state;

  cfg_delay_timer #(
    .CYCLES (DELAY_CYCLES)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_delay),
    .en      (state == ST_DELAY),
    .expired (delay_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_next = ST_FETCH;
      ST_FETCH:                   state_next = ST_DECODE;
      ST_DECODE: begin
        if (is_end)        state_next = ST_DONE;
        else if (is_delay) state_next = ST_DELAY;
        else               state_next = ST_SEND;
      end
      ST_SEND:                    if (sccb.req_ready) state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (sccb.wr_done) begin
          if (!sccb.wr_nack) state_next = at_last ? ST_DONE : ST_FETCH;
          else if (retry_left) state_next = ST_SEND;
          else                 state_next = ST_ERROR;
        end
      end
      ST_DELAY:                   if (delay_expired) state_next = at_last ? ST_DONE : ST_FETCH;
      default:                    state_next = ST_IDLE;
    endcase
  end

  // Status and req_valid come straight from the registered state, so neither
  // req_ready nor wr_done can reach them combinationally.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    sccb.req_valid = 1'b0;
    start_walk     = 1'b0;
    load_delay     = 1'b0;
    latch_req      = 1'b0;
    wr_ack         = 1'b0;
    wr_retry       = 1'b0;
    advance        = 1'b0;
    case (state)
      ST_IDLE:  start_walk = start;
      ST_DONE: begin
        done       = 1'b1;
        start_walk = start;
      end
      ST_ERROR: begin
        err        = 1'b1;
        start_walk = start;
      end
      ST_FETCH: busy = 1'b1;
      ST_DECODE: begin
        busy       = 1'b1;
        load_delay = !is_end && is_delay;
        latch_req  = !is_end && !is_delay;
      end
      ST_SEND: begin
        busy           = 1'b1;
        sccb.req_valid = 1'b1;
      end
      ST_WAIT_DONE: begin
        busy     = 1'b1;
        wr_ack   = sccb.wr_done && !sccb.wr_nack;
        wr_retry = sccb.wr_done && sccb.wr_nack && retry_left;
        advance  = wr_ack;
      end
      ST_DELAY: begin
        busy    = 1'b1;
        advance = delay_expired;
      end
      default: ;
    endcase
  end

  // The table pointer never wraps: advancing from the last address ends the walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr      <= '0;
      wr_count      <= '0;
      retry         <= '0;
      sccb.req_reg  <= '0;
      sccb.req_data <= '0;
    end else begin
      if (start_walk) begin
        rom_addr <= '0;
        wr_count <= '0;
        retry    <= '0;
      end
      if (advance && !at_last) begin
        rom_addr <= rom_addr + ADDR_W'(1);
      end
      if (wr_ack) begin
        wr_count <= wr_count + (ADDR_W + 1)'(1);
        retry    <= '0;
      end
      if (wr_retry) begin
        retry <= retry + RETRY_W'(1);
      end
      if (latch_req) begin
        sccb.req_reg  <= rom_data[ENTRY_W-1:VAL_W];
        sccb.req_data <= rom_data[VAL_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for the config sequencer: a registered ROM, an SCCB slave with NACK
// plan and stalls, directed table vectors and randomized tables vs a model.
module tb_ov7670_config_sequencer;
  import ov7670_cfg_pkg::*;

  localparam int ADDR_W  = 2;
  localparam int ENTRIES = 4;
  localparam int DLY     = 20;
  localparam int MAXR    = 3;
  localparam int BUDGET  = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              busy, done, err;
  logic [ADDR_W:0]   wr_count;
  cfg_state_t        fsm_state;

  ov7670_config_sequencer_if #(.REG_W(8), .VAL_W(8)) sccb ();

  ov7670_config_sequencer #(
    .ADDR_W(ADDR_W), .REG_W(8), .VAL_W(8),
    .END_MARK(16'hFFFF), .DELAY_MARK(16'hFFF0),
    .DELAY_CYCLES(DLY), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb(sccb),
    .busy(busy), .done(done), .err(err),
    .wr_count(wr_count), .fsm_state(fsm_state)
  );

  logic [15:0] rom [ENTRIES];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  bit          nack_q[$];
  int  exp_delays;
  int  dly_cnt = 0;
  int  lat = 3;
  bit  ready_rand = 1'b0;
  int  stall_left = 0;
  int  held_cnt = 0;
  int  held_bad = 0;
  logic [15:0] held_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0][15:0] tbl;
    logic [3:0][2:0]  nacks;
    logic             exp_done;
    logic             exp_err;
    logic [2:0]       exp_count;
    logic [1:0]       exp_addr;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] e0, e1, e2, e3,
                              input logic [2:0] n0, n1, n2, n3,
                              input logic d, input logic er,
                              input logic [2:0] c, input logic [1:0] a);
    vec_t v;
    v.tbl = {e3, e2, e1, e0};
    v.nacks = {n3, n2, n1, n0};
    v.exp_done = d;
    v.exp_err = er;
    v.exp_count = c;
    v.exp_addr = a;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Walks the table as a list: END stops, DELAY adds DLY cycles, a write entry
  // with n NACKs is requested min(n, MAXR)+1 times and fails if n > MAXR.
  task automatic build_model(input vec_t v, output bit m_done, output bit m_err,
                             output int m_count, output int m_addr);
    logic [15:0] e;
    int n;
    exp_q.delete();
    nack_q.delete();
    exp_delays = 0;
    m_done = 1'b0; m_err = 1'b0; m_count = 0; m_addr = ENTRIES - 1;
    for (int i = 0; i < ENTRIES; i++) begin
      e = v.tbl[i];
      if (e == 16'hFFFF) begin
        m_done = 1'b1; m_addr = i;
        return;
      end
      if (e == 16'hFFF0) begin
        exp_delays++;
        continue;
      end
      n = int'(v.nacks[i]);
      for (int k = 0; k <= MAXR && k <= n; k++) begin
        exp_q.push_back(e);
        nack_q.push_back(k < n);
      end
      if (n > MAXR) begin
        m_err = 1'b1; m_addr = i;
        return;
      end
      m_count++;
    end
    m_done = 1'b1;
  endtask

  // ---------------- SCCB slave driver ----------------
  int  pend = 0;
  bit  pend_nack = 1'b0;
  initial begin
    sccb.req_ready = 1'b0;
    sccb.wr_done = 1'b0;
    sccb.wr_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; stall_left = 0;
        sccb.wr_done = 1'b0; sccb.wr_nack = 1'b0; sccb.req_ready = 1'b0;
        continue;
      end
      if (sccb.wr_done) begin
        sccb.wr_done = 1'b0; sccb.wr_nack = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          sccb.wr_done = 1'b1; sccb.wr_nack = pend_nack;
        end
      end
      if (sccb.req_valid && stall_left > 0) begin
        if (held_cnt == 0) held_val = {sccb.req_reg, sccb.req_data};
        else if ({sccb.req_reg, sccb.req_data} !== held_val) held_bad++;
        held_cnt++;
        stall_left--;
        sccb.req_ready = 1'b0;
      end else begin
        sccb.req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (sccb.req_valid && sccb.req_ready) begin
        if (held_cnt > 0) held_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_req", {sccb.req_reg, sccb.req_data}, 32'hDEAD);
          pend_nack = 1'b0;
        end else begin
          check("req", {sccb.req_reg, sccb.req_data}, exp_q.pop_front());
          pend_nack = nack_q.pop_front();
        end
        pend = lat;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && fsm_state == ST_DELAY) dly_cnt++;
  end

  // ---------------- walk tasks ----------------
  task automatic begin_walk(input vec_t v, output bit m_done, output bit m_err,
                            output int m_count, output int m_addr);
    for (int i = 0; i < ENTRIES; i++) rom[i] = v.tbl[i];
    build_model(v, m_done, m_err, m_count, m_addr);
    @(negedge clk);
    dly_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_done", done, 1'b0);
    check("start_err", err, 1'b0);
    check("start_count", wr_count, 0);
    check("start_addr", rom_addr, 0);
  endtask

  task automatic finish_walk(input bit e_done, input bit e_err, input int e_count, input int e_addr);
    int cyc = 0;
    while (!(done || err) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check("walk_timeout", (cyc >= BUDGET), 1'b0);
    check("end_done", done, e_done);
    check("end_err", err, e_err);
    check("end_busy", busy, 1'b0);
    check("end_count", wr_count, e_count);
    check("end_addr", rom_addr, e_addr);
    check("req_left", exp_q.size(), 0);
    check("delay_cycles", dly_cnt, exp_delays * DLY);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_valid"}, sccb.req_valid, 1'b0);
    check({tag, "_bus"}, {sccb.req_reg, sccb.req_data}, 0);
    check({tag, "_status"}, {done, err, wr_count, rom_addr}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main test ----------------
  vec_t vecs[6];
  bit m_done, m_err;
  int m_count, m_addr;

  initial begin
    vecs[0] = mk(16'h1280, 16'h1101, 16'hFFFF, 16'h0000, 0, 0, 0, 0, 1, 0, 2, 2);
    vecs[1] = mk(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF, 0, 0, 0, 0, 1, 0, 2, 3);
    vecs[2] = mk(16'h40D0, 16'hFFFF, 16'h0000, 16'h0000, 2, 0, 0, 0, 1, 0, 1, 1);
    vecs[3] = mk(16'h1280, 16'h40D0, 16'hFFFF, 16'h0000, 0, 4, 0, 0, 0, 1, 1, 1);
    vecs[4] = mk(16'h0102, 16'h0304, 16'h0506, 16'h0708, 0, 0, 0, 0, 1, 0, 4, 3);
    vecs[5] = vecs[4];
    for (int i = 0; i < ENTRIES; i++) rom[i] = 16'h0000;

    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", sccb.req_valid, 1'b0);
    check("rst_bus", {sccb.req_reg, sccb.req_data}, 0);
    check("rst_status", {done, err, wr_count, rom_addr}, 0);
    check("rst_state", fsm_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    lat = 3;
    ready_rand = 1'b0;
    for (int i = 0; i < 6; i++) begin
      begin_walk(vecs[i], m_done, m_err, m_count, m_addr);
      finish_walk(vecs[i].exp_done, vecs[i].exp_err, int'(vecs[i].exp_count), int'(vecs[i].exp_addr));
    end

    // req_ready held low for 5 request cycles on the first write
    held_cnt = 0; held_bad = 0;
    stall_left = 5;
    begin_walk(vecs[0], m_done, m_err, m_count, m_addr);
    finish_walk(1'b1, 1'b0, 2, 2);
    check("stall_hold", (held_cnt >= 5), 1'b1);
    check("stall_stable", held_bad, 0);
    held_cnt = 0;

    // reset while in DELAY, then a full walk
    begin_walk(vecs[1], m_done, m_err, m_count, m_addr);
    for (int c = 0; c < BUDGET && fsm_state != ST_DELAY; c++) @(negedge clk);
    check("reach_delay", fsm_state, ST_DELAY);
    async_reset_check("rst_delay");
    begin_walk(vecs[1], m_done, m_err, m_count, m_addr);
    finish_walk(1'b1, 1'b0, 2, 3);

    // reset while a request is pending in SEND
    stall_left = 50;
    begin_walk(vecs[4], m_done, m_err, m_count, m_addr);
    for (int c = 0; c < BUDGET && !sccb.req_valid; c++) @(negedge clk);
    check("reach_send", sccb.req_valid, 1'b1);
    async_reset_check("rst_send");
    held_cnt = 0;
    begin_walk(vecs[4], m_done, m_err, m_count, m_addr);
    finish_walk(1'b1, 1'b0, 4, 3);

    // randomized tables, NACK plans, latencies and ready patterns
    ready_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      vec_t v;
      for (int i = 0; i < ENTRIES; i++) begin
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0)      v.tbl[i] = 16'hFFFF;
        else if (r == 1) v.tbl[i] = 16'hFFF0;
        else             v.tbl[i] = make_entry(8'($urandom_range(0, 254)), 8'($urandom_range(0, 255)));
        v.nacks[i] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
      end
      lat = int'($urandom_range(1, 4));
      begin_walk(v, m_done, m_err, m_count, m_addr);
      finish_walk(m_done, m_err, m_count, m_addr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
